// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants for the pipelined adder/subtractor.
// Mode encoding used on the mode input and carried down the pipeline.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG_WIDTH-bit ripple slice.
// Ports: a, b, cin in; s, cout, c_msb (carry into slice MSB) out.
module addsub_seg #(
    parameter int SEG_WIDTH = 4
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 cout,
    output logic                 c_msb
);

    logic [SEG_WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[SEG_WIDTH];
    assign c_msb = c[SEG_WIDTH-1];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit add/sub, SEG_WIDTH bits per stage,
// valid/ready on both sides. Ports: clk, rst_n, in_valid/in_ready,
// data0, data1, mode (1=add), out_valid/out_ready, sum,
// final_carry_out, overflow. Define ADDSUB_PIPE_SAT_EN to saturate
// sum on signed overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] data0,
    input  logic [0:WIDTH-1] data1,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] sum,
    output logic             final_carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;

    typedef struct packed {
        logic             valid;
        logic             mode;
        logic             carry;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    // pipe[0] holds captured operands (B already conditioned);
    // pipe[k] holds a payload with k slices resolved.
    stage_t pipe [STAGES];
    stage_t nxt  [STAGES];

    logic [SEG_WIDTH-1:0] seg_s  [STAGES];
    logic                 seg_co [STAGES];
    logic                 seg_cm [STAGES];

    logic             advance;
    logic [WIDTH-1:0] wrap_d;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        addsub_seg #(
            .SEG_WIDTH(SEG_WIDTH)
        ) u_seg (
            .a    (pipe[k].a[k*SEG_WIDTH +: SEG_WIDTH]),
            .b    (pipe[k].b[k*SEG_WIDTH +: SEG_WIDTH]),
            .cin  (pipe[k].carry),
            .s    (seg_s[k]),
            .cout (seg_co[k]),
            .c_msb(seg_cm[k])
        );
    end

    always_comb begin
        nxt[0]       = '0;
        nxt[0].valid = in_valid;
        nxt[0].mode  = mode;
        nxt[0].a     = data0;
        nxt[0].b     = (mode == MODE_ADD) ? data1 : ~data1;
        nxt[0].carry = (mode == MODE_SUB);
        for (int k = 1; k < STAGES; k++) begin
            nxt[k]       = pipe[k-1];
            nxt[k].carry = seg_co[k-1];
            nxt[k].psum[(k-1)*SEG_WIDTH +: SEG_WIDTH] = seg_s[k-1];
        end
    end

    always_comb begin
        wrap_d = pipe[LAST].psum;
        wrap_d[LAST*SEG_WIDTH +: SEG_WIDTH] = seg_s[LAST];
        ovf_d  = seg_cm[LAST] ^ seg_co[LAST];
    end

`ifdef ADDSUB_PIPE_SAT_EN
    // Overflow means both operands share a sign, so A's MSB
    // tells which limit the true result ran past.
    always_comb begin
        sum_d = wrap_d;
        if (ovf_d) begin
            sum_d = pipe[LAST].a[WIDTH-1]
                  ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_d = wrap_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
            out_valid       <= 1'b0;
            sum             <= '0;
            final_carry_out <= 1'b0;
            overflow        <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= nxt[k];
            end
            out_valid       <= pipe[LAST].valid;
            sum             <= sum_d;
            final_carry_out <= seg_co[LAST];
            overflow        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed + scoreboard bench for addsub_pipe
// (WIDTH=8, SEG_WIDTH=4, latency 2).
module tb_addsub_pipe;
    import addsub_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] data0;
    logic [0:7] data1;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] sum;
    logic       final_carry_out;
    logic       overflow;

    typedef struct {
        logic [9:0] exp;
        int         acc;
        bit         lat;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    bit         prev_stall = 0;
    logic [7:0] held_sum;
    logic       held_c;
    logic       held_o;

    addsub_pipe #(
        .WIDTH(8),
        .SEG_WIDTH(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data0          (data0),
        .data1          (data1),
        .mode           (mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sum            (sum),
        .final_carry_out(final_carry_out),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carry, sum} for an 8-bit add/sub.
    function automatic logic [9:0] model(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic m);
        logic [7:0] bb;
        logic [8:0] full;
        logic [7:0] s;
        logic       o;
        bb   = m ? b : ~b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, ~m};
        s    = full[7:0];
        o    = (a[7] == bb[7]) && (s[7] != a[7]);
`ifdef ADDSUB_PIPE_SAT_EN
        if (o) s = a[7] ? 8'h80 : 8'h7F;
`endif
        return {o, full[8], s};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the
    // edge that accepted the operands.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic m, input bit lat,
                         input bit need_ready);
        int  n;
        sb_t e;
        n        = 0;
        in_valid = 1'b1;
        data0    = a;
        data1    = b;
        mode     = m;
        @(negedge clk);
        if (need_ready) chk("stream_in_ready", in_ready, 1);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", in_ready, 1);
        e.exp = model(a, b, m);
        e.acc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum, held_sum);
                chk("hold_carry", final_carry_out, held_c);
                chk("hold_ovf", overflow, held_o);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", sum, e.exp[7:0]);
                    chk("carry", final_carry_out, e.exp[8]);
                    chk("ovf", overflow, e.exp[9]);
                    if (e.lat) chk("latency", cyc - e.acc, 2);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_sum   = sum;
            held_c     = final_carry_out;
            held_o     = overflow;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data0     = '0;
        data1     = '0;
        mode      = MODE_ADD;
        #1 rst_n  = 1'b0;
        #11;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_carry", final_carry_out, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        drive(8'h07, 8'hFC, MODE_ADD, 1, 0);
        idle(3);
        drive(8'h7F, 8'h01, MODE_ADD, 1, 0);
        drive(8'h81, 8'h78, MODE_SUB, 1, 0);
        drive(8'h01, 8'h5F, MODE_SUB, 1, 0);
        drive(8'h80, 8'h01, MODE_SUB, 1, 0);
        drive(8'h00, 8'h00, MODE_SUB, 1, 0);
        drive(8'hFF, 8'h01, MODE_ADD, 1, 0);
        drive(8'h80, 8'h80, MODE_ADD, 1, 0);
        idle(4);

        drive(8'h31, 8'h3F, MODE_ADD, 1, 1);
        drive(8'h8F, 8'h76, MODE_ADD, 1, 1);
        drive(8'h81, 8'h7E, MODE_ADD, 1, 1);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1, 0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(5);
        chk("drain_empty_1", sb.size(), 0);

        out_ready = 1'b0;
        drive(8'h12, 8'h34, MODE_ADD, 0, 0);
        drive(8'h7F, 8'h7F, MODE_ADD, 0, 0);
        drive(8'h80, 8'h7F, MODE_SUB, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(6);
        chk("drain_empty_2", sb.size(), 0);

        out_ready = 1'b0;
        drive(8'h11, 8'h22, MODE_ADD, 0, 0);
        drive(8'h33, 8'h44, MODE_SUB, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_carry", final_carry_out, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_ready", in_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        drive(8'h40, 8'h40, MODE_ADD, 1, 1);
        idle(4);
        chk("drain_empty_3", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
